// File: rtl/seq_div_16bit_pkg.sv
// Shared types and constants for the sequential 16-bit divider.
// Optional feature macro used by this slice: DIV_UNSIGNED_EN.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } div_state_t;

  localparam logic [DIV_W-1:0] INT_MIN = 16'h8000;
  localparam logic [DIV_W-1:0] DBZ_Q   = 16'hFFFF;

  function automatic logic [DIV_W-1:0] neg16(input logic [DIV_W-1:0] x);
    return DIV_W'(~x + DIV_W'(1));
  endfunction

  // -32768 maps to 0x8000, read as unsigned magnitude
  function automatic logic [DIV_W-1:0] abs16(input logic [DIV_W-1:0] x);
    return x[DIV_W-1] ? neg16(x) : x;
  endfunction

endpackage

// File: rtl/seq_div_16bit_if.sv
// Start/done handshake and operand/result bundle of the divider.
// DIV_UNSIGNED_EN adds the per-operation unsigned select 'uns'.
interface seq_div_16bit_if;
  import div_pkg::*;

  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

`ifdef DIV_UNSIGNED_EN
  logic             uns;

  modport master (output start, dividend, divisor, uns,
                  input  busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input  start, dividend, divisor, uns,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
`endif

endinterface

// File: rtl/seq_div_16bit_cla.sv
// 16-bit carry-lookahead adder: 4-bit groups with a lookahead carry across groups.
module cla_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c0,
  output logic [15:0] o_sum,
  output logic        o_c16
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | ((&w_p[4*k+3 -: 3]) & w_g[4*k]);
      w_gp[k] = &w_p[4*k+3 -: 4];
    end
  end

  // Group carries resolved in parallel from c0
  assign w_gc[0] = i_c0;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_c0);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c0);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_c0);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_c0);

  always_comb begin
    logic v_c;
    v_c = 1'b0;
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      v_c = w_gc[k];
      for (int j = 0; j < 4; j++) begin
        w_c[4*k+j] = v_c;
        v_c = w_g[4*k+j] | (w_p[4*k+j] & v_c);
      end
    end
  end

  assign o_sum = w_p ^ w_c;
  assign o_c16 = w_gc[4];

endmodule

// File: rtl/seq_div_16bit.sv
// Sequential signed radix-2 restoring divider, one quotient bit per cycle.
// DIV_UNSIGNED_EN adds an unsigned mode selected per operation.
module seq_div_16bit
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input logic             clk,
  input logic             rst,
  seq_div_16bit_if.slave  bus
);

  if (DIV_W != 16) begin : g_bad_width
    $error("seq_div_16bit: DIV_W must be 16 (trial adder is the 16-bit CLA)");
  end

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_dq;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_d;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [DIV_W-1:0] r_quot_o;
  logic [DIV_W-1:0] r_rem_o;
  logic             r_dbz_o;
  logic             r_ovf_o;

  logic             w_signed;
  logic             w_t_hi;
  logic [DIV_W-1:0] w_t;
  logic [DIV_W-1:0] w_diff;
  logic             w_c16;
  logic             w_sub;
  logic [DIV_W-1:0] w_a_mag;
  logic [DIV_W-1:0] w_d_mag;

`ifdef DIV_UNSIGNED_EN
  assign w_signed = ~bus.uns;
  // Unsigned divisors up to 0xFFFF: the shifted-out r[15] is bit 16 of t
  assign w_t_hi   = r_rem[DIV_W-1];
`else
  assign w_signed = 1'b1;
  assign w_t_hi   = 1'b0;
`endif

  assign w_a_mag = w_signed ? abs16(bus.dividend) : bus.dividend;
  assign w_d_mag = w_signed ? abs16(bus.divisor)  : bus.divisor;

  assign w_t   = {r_rem[DIV_W-2:0], r_dq[DIV_W-1]};
  assign w_sub = w_c16 | w_t_hi;

  cla_16bit u_cla (
    .i_a   (w_t),
    .i_b   (~r_d),
    .i_c0  (1'b1),
    .o_sum (w_diff),
    .o_c16 (w_c16)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next_state = (bus.divisor == '0) ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(DIV_W - 1)) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; dq holds the dividend and collects quotient bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dq     <= '0;
      r_rem    <= '0;
      r_d      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
      r_dbz_o  <= 1'b0;
      r_ovf_o  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_dq     <= w_a_mag;
            r_d      <= w_d_mag;
            r_dbz    <= (bus.divisor == '0);
            // On divide-by-zero the remainder register carries |dividend| through FIX
            r_rem    <= (bus.divisor == '0) ? w_a_mag : '0;
            r_sign_q <= w_signed & (bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1]);
            r_sign_r <= w_signed & bus.dividend[DIV_W-1];
            r_ovf    <= w_signed & (bus.dividend == INT_MIN) & (bus.divisor == DBZ_Q);
          end
        end
        S_CALC: begin
          r_rem <= w_sub ? w_diff : w_t;
          r_dq  <= {r_dq[DIV_W-2:0], w_sub};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_quot_o <= r_dbz ? DBZ_Q : (r_sign_q ? neg16(r_dq) : r_dq);
          r_rem_o  <= r_sign_r ? neg16(r_rem) : r_rem;
          r_dbz_o  <= r_dbz;
          r_ovf_o  <= r_ovf & ~r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot_o;
  assign bus.remainder   = r_rem_o;
  assign bus.div_by_zero = r_dbz_o;
  assign bus.overflow    = r_ovf_o;

endmodule

// File: tb/tb_seq_div_16bit.sv
// Directed bench for seq_div_16bit; define DIV_UNSIGNED_EN to also cover unsigned mode.
module tb_seq_div_16bit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  seq_div_16bit_if bus ();

  seq_div_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(input logic [15:0] a, input logic [15:0] d, input logic u);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = d;
`ifdef DIV_UNSIGNED_EN
    bus.uns      = u;
`else
    if (u) $display("[TB] unsigned request ignored in signed build");
`endif
  endtask

  // Waits (bounded) for done; returns edges counted after the accept edge and busy-high samples seen
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 1;
    while (n < 40 && bus.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (bus.done !== 1'b1 && bus.busy === 1'b1) nbusy++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input logic u, input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eovf, input int lat);
    int n;
    int nb;
    drive_ops(a, d, u);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy_accept"}, 32'(bus.busy), 32'd1);
    wait_done(n, nb);
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(lat));
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, ".q"}, 32'(bus.quotient), 32'(eq));
    chk({tag, ".r"}, 32'(bus.remainder), 32'(er));
    chk({tag, ".flags"}, {30'd0, bus.div_by_zero, bus.overflow}, {30'd0, edbz, eovf});
  endtask

  initial begin
    int n;
    int nb;
    int done_cyc;
    int ndone;
    logic [15:0] ra;
    logic [15:0] rd;
    int ia;
    int id;
    logic [15:0] eq;
    logic [15:0] er;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_UNSIGNED_EN
    bus.uns      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder},
        {4'b0000, 28'd0});
    rst = 1'b0;

    // Basic and sign combinations
    run_div("p100_7",   16'd100,   16'd7,     1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 17);
    @(posedge clk); #1;
    chk("p100_7.done_pulse", 32'(bus.done), 32'd0);
    chk("p100_7.hold_q", 32'(bus.quotient), 32'h000E);
    run_div("m100_7",   16'hFF9C,  16'd7,     1'b0, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
    run_div("p100_m7",  16'd100,   16'hFFF9,  1'b0, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17);
    run_div("m100_m7",  16'hFF9C,  16'hFFF9,  1'b0, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 17);

    // Divide by zero
    run_div("dbz_1234", 16'd1234,  16'd0,     1'b0, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1);
    run_div("dbz_m5",   16'hFFFB,  16'd0,     1'b0, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1);

    // INT_MIN cases
    run_div("min_m1",   16'h8000,  16'hFFFF,  1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
    run_div("min_p1",   16'h8000,  16'h0001,  1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 17);

    // start while busy is ignored
    drive_ops(16'd100, 16'd7, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 40 && bus.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n == 3 || n == 8) drive_ops(16'd5, 16'd1, 1'b0);
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("ignore.latency", 32'(n), 32'd17);
    chk("ignore.qr", {bus.quotient, bus.remainder}, {16'h000E, 16'h0002});

    // Back-to-back: start presented in the done cycle
    done_cyc = cyc;
    run_div("b2b", 16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 17);
    chk("b2b.spacing", 32'(cyc - done_cyc), 32'd18);

    // Reset mid-operation at cnt=7
    drive_ops(16'd100, 16'd7, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.outs", {bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder},
        {4'b0000, 28'd0});
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst.no_done", 32'(ndone), 32'd0);
    run_div("max_max", 16'd32767, 16'd32767, 1'b0, 16'd1, 16'd0, 1'b0, 1'b0, 17);

`ifdef DIV_UNSIGNED_EN
    run_div("uns_ffff_2", 16'hFFFF, 16'd2, 1'b1, 16'd32767, 16'd1, 1'b0, 1'b0, 17);
    run_div("uns_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'd1, 16'd0, 1'b0, 1'b0, 17);
    run_div("uns_8000_ffff", 16'h8000, 16'hFFFF, 1'b1, 16'd0, 16'h8000, 1'b0, 1'b0, 17);
`endif

    // Random signed sweep against the language's truncating / and %
    for (int k = 0; k < 1500; k++) begin
      ra = 16'($urandom);
      rd = 16'($urandom);
      if (k % 50 == 0) rd = 16'd0;
      if (k % 97 == 0) ra = 16'h8000;
      ia = int'($signed(ra));
      id = int'($signed(rd));
      if (id == 0) begin
        eq = 16'hFFFF;
        er = ra;
      end else begin
        eq = 16'(ia / id);
        er = 16'(ia % id);
      end
      run_div($sformatf("rnd%0d", k), ra, rd, 1'b0, eq, er, (id == 0),
              (ra == 16'h8000 && rd == 16'hFFFF), (id == 0) ? 1 : 17);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
